// File: rtl/i2s_slave_port_if.sv
// I2S slave pins plus parallel TX/RX words; slave = codec side, master = driving side.
// No backpressure: the serial side is clocked by the external master.
interface i2s_slave_port_if #(
  parameter int DATA_BITS = 24
);
  logic                 BCLK;
  logic                 LRCLK;
  logic                 DAC_SDATA;
  logic                 ADC_SDATA;
  logic [DATA_BITS-1:0] LeftTxData;
  logic [DATA_BITS-1:0] RightTxData;
  logic [DATA_BITS-1:0] LeftRxData;
  logic [DATA_BITS-1:0] RightRxData;
  logic                 NewFrame;
  logic                 FrameErr;

  modport slave (
    input  BCLK, LRCLK, DAC_SDATA, LeftTxData, RightTxData,
    output ADC_SDATA, LeftRxData, RightRxData, NewFrame, FrameErr
  );

  modport master (
    output BCLK, LRCLK, DAC_SDATA, LeftTxData, RightTxData,
    input  ADC_SDATA, LeftRxData, RightRxData, NewFrame, FrameErr
  );
endinterface

// File: rtl/i2s_slave_port.sv
// I2S slave transceiver: pin->rise/fall 3 clk, RX word +1 clk after last rise, BCLK fall->ADC_SDATA 4 clk; no backpressure.
// Optional half-frame length check (FrameErr) enabled by macro I2S_SLAVE_FRAME_CHECK_EN.
module i2s_slave_port #(
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic              audio_clk,
  input  logic              reset,
  i2s_slave_port_if.slave   bus
);

  localparam logic [0:0] SYNC_WAIT = 1'b0;
  localparam logic [0:0] ACTIVE    = 1'b1;

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);

  if (SLOT_BITS < DATA_BITS + 1) begin : g_slot_check
    $error("SLOT_BITS must be at least DATA_BITS+1");
  end

  logic [2:0] bclk_sync;
  logic [2:0] lr_sync;
  logic [2:0] dat_sync;
  logic       rise;
  logic       fall;
  logic       lr;
  logic       dat;

  // LRCLK/DATA get the same depth as BCLK edge detection so they line up with rise.
  always_ff @(posedge audio_clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      dat_sync  <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bus.BCLK};
      lr_sync   <= {lr_sync[1:0], bus.LRCLK};
      dat_sync  <= {dat_sync[1:0], bus.DAC_SDATA};
      rise      <= bclk_sync[1] & ~bclk_sync[2];
      fall      <= ~bclk_sync[1] & bclk_sync[2];
    end
  end

  assign lr  = lr_sync[2];
  assign dat = dat_sync[2];

  logic [0:0]           state;
  logic                 armed;
  logic                 prev_lr;
  logic                 channel;
  logic                 left_done;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] rx_sh;
  logic [DATA_BITS-1:0] left_rx;
  logic [DATA_BITS-1:0] right_rx;
  logic                 new_frame;
  logic [CW-1:0]        tx_cnt;
  logic [DATA_BITS-1:0] tx_sh;
  logic [DATA_BITS-1:0] snap_l;
  logic [DATA_BITS-1:0] snap_r;
  logic                 adc;
  logic                 in_active;
  logic                 xfer;

  assign in_active = (state == ACTIVE);
  assign xfer      = rise & armed & (lr != prev_lr);

  always_ff @(posedge audio_clk) begin
    if (reset) begin
      state     <= SYNC_WAIT;
      armed     <= 1'b0;
      prev_lr   <= 1'b0;
      channel   <= 1'b0;
      left_done <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      left_rx   <= '0;
      right_rx  <= '0;
      new_frame <= 1'b0;
      tx_cnt    <= '0;
      tx_sh     <= '0;
      snap_l    <= '0;
      snap_r    <= '0;
      adc       <= 1'b0;
    end else begin
      new_frame <= 1'b0;
      if (rise) begin
        armed   <= 1'b1;
        prev_lr <= lr;
      end

      // The bit sampled on a transition rise is the tail of the old slot.
      if (xfer) begin
        state   <= ACTIVE;
        channel <= lr;
        bit_cnt <= '0;
        tx_cnt  <= '0;
        if (!lr) begin
          snap_l <= bus.LeftTxData;
          snap_r <= bus.RightTxData;
          tx_sh  <= bus.LeftTxData;
        end else begin
          tx_sh  <= snap_r;
        end
      end else if (rise && in_active && (bit_cnt < CNT_FULL)) begin
        rx_sh   <= {rx_sh[DATA_BITS-2:0], dat};
        bit_cnt <= bit_cnt + CW'(1);
        if (bit_cnt == CNT_LAST) begin
          if (channel) begin
            right_rx  <= {rx_sh[DATA_BITS-2:0], dat};
            new_frame <= left_done;
          end else begin
            left_rx   <= {rx_sh[DATA_BITS-2:0], dat};
            left_done <= 1'b1;
          end
        end
      end

      if (fall && in_active) begin
        if (tx_cnt < CNT_FULL) begin
          adc    <= tx_sh[DATA_BITS-1];
          tx_sh  <= tx_sh << 1;
          tx_cnt <= tx_cnt + CW'(1);
        end else begin
          adc    <= 1'b0;
        end
      end
    end
  end

  assign bus.ADC_SDATA   = adc;
  assign bus.LeftRxData  = left_rx;
  assign bus.RightRxData = right_rx;
  assign bus.NewFrame    = new_frame;

`ifdef I2S_SLAVE_FRAME_CHECK_EN
  localparam int SW = $clog2(SLOT_BITS + 2);
  localparam logic [SW-1:0] SLOT_LEN = SW'(SLOT_BITS);

  logic [SW-1:0] slot_cnt;
  logic          frame_err;

  // The transition rise itself is the first rise of the new slot; the lock transition is not judged.
  always_ff @(posedge audio_clk) begin
    if (reset) begin
      slot_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (xfer) begin
        frame_err <= in_active && (slot_cnt != SLOT_LEN);
        slot_cnt  <= SW'(1);
      end else if (rise && in_active && (slot_cnt != '1)) begin
        slot_cnt  <= slot_cnt + SW'(1);
      end
    end
  end

  assign bus.FrameErr = frame_err;
`else
  assign bus.FrameErr = 1'b0;
`endif

endmodule

// File: doc/i2s_slave_port.md
# i2s_slave_port

Far-end I2S slave transceiver: the codec-side counterpart of `de_coder_port`. It receives BCLK and LRCLK from the I2S master and captures the master's DAC_SDATA stream into parallel left/right words. It also serializes its own left/right words onto ADC_SDATA back to the master. It serves as the codec model for loopback benches and as the slave port when the FPGA is clocked by an external master.

## Interface
- `DATA_BITS`, 24: sample width per channel.
- `SLOT_BITS`, 32: BCLK periods per half-frame (per channel); must be ≥ DATA_BITS+1.

Ports:
- `audio_clk`, input, 1: the single system clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `BCLK`, input, 1: bit clock from the master; asynchronous to audio_clk.
- `LRCLK`, input, 1: word select from the master; 0 = left, 1 = right.
- `DAC_SDATA`, input, 1: serial data from the master.
- `ADC_SDATA`, output, 1: serial data to the master.
- `LeftTxData` / `RightTxData`, input, DATA_BITS: words to transmit.
- `LeftRxData` / `RightRxData`, output, DATA_BITS: received words.
- `NewFrame`, output, 1: one-cycle pulse when a complete left+right pair has been received.
- `FrameErr`, output, 1: one-cycle pulse on a half-frame length error (see Configuration).

## Operation
- **Input synchronization**
  - BCLK, LRCLK and DAC_SDATA each pass through a 2-flop synchronizer.
  - A third flop on the synchronized BCLK provides edge detection: `rise` = 0→1, `fall` = 1→0.
- **States: `SYNC_WAIT` → `ACTIVE`**
  - Reset enters `SYNC_WAIT`. The first `rise` only records LRCLK into `prev_lr`.
  - A later `rise` with LRCLK ≠ `prev_lr` enters `ACTIVE` and is handled as a transition (below).
  - `ACTIVE` is left only by reset.
- **I2S framing**
  - The MSB follows the LRCLK change by one BCLK.
  - On a `rise` where LRCLK ≠ `prev_lr` (transition):
    - `bit_cnt` ← 0; channel ← LRCLK.
    - The TX shift register loads the snapshot word for the new channel.
    - The bit sampled on this edge belongs to the previous slot and is discarded.
- **Receive**
  - On each `rise` in `ACTIVE` without a transition, while `bit_cnt` < DATA_BITS: shift DAC_SDATA in MSB-first and increment `bit_cnt`.
  - When `bit_cnt` reaches DATA_BITS, copy the shift register into LeftRxData or RightRxData according to channel.
  - Bits beyond DATA_BITS in the slot are ignored.
- **NewFrame**
  - Pulses on the cycle RightRxData updates, but only if a left word has completed since entering `ACTIVE`.
  - Result: after lock, the first pulse marks the first full pair.
- **Transmit**
  - On each `fall` in `ACTIVE`, ADC_SDATA ← next TX bit, MSB first, for DATA_BITS falls after the transition.
  - After that it drives 0 for the rest of the slot.
  - In `SYNC_WAIT`, ADC_SDATA = 0.
- **TX snapshot**
  - LeftTxData and RightTxData are both registered on the transition into left (LRCLK 1→0).
  - Changes mid-frame never tear a frame; they take effect the next frame.
  - On the lock transition, the snapshot is taken if lock enters left. If lock enters right, the right slot transmits zeros.

## Timing
- **Reset values:** ADC_SDATA, LeftRxData, RightRxData, NewFrame and FrameErr are 0. The state is `SYNC_WAIT`. All counters, shift registers and snapshots are cleared.
- **Reset mid-operation:** everything returns to reset values on the next audio_clk edge, with no partial word latched. The block must re-lock on a new LRCLK transition.
- **Latency:**
  - Pin edge to `rise`/`fall`: 3 audio_clk cycles.
  - RxData and NewFrame update 1 cycle after the `rise` of the DATA_BITS-th bit.
  - BCLK falling pin to ADC_SDATA change: 4 audio_clk cycles.
- **Requirement:** BCLK high and low phases are each ≥ 4 audio_clk periods, so audio_clk ≥ 8× BCLK. Behaviour is undefined otherwise.
- **Simultaneous events:** a transition `rise` takes priority over the receive shift. The RxData latch and the transition can never coincide, since SLOT_BITS > DATA_BITS.

## Configuration
- Macro `I2S_SLAVE_FRAME_CHECK_EN`.
- **Defined:** a counter counts `rise` edges between consecutive transitions in `ACTIVE`. If the count ≠ SLOT_BITS at a transition:
  - FrameErr pulses for 1 cycle.
  - The counter restarts.
  - The receive/transmit process continues unchanged.
- **Undefined:** the counter is absent and FrameErr is tied to 0.

## Test plan
- **Reset:** hold `reset` for 3 cycles with BCLK toggling → every output is 0 and no NewFrame occurs before the first LRCLK transition.
- **Receive:**
  - Stimulus: bench master at BCLK = audio_clk/8 with 32-bit slots sends left 24'hA5A5A5 and right 24'h5A5A5A.
  - Required: LeftRxData = A5A5A5 and RightRxData = 5A5A5A; exactly one NewFrame per frame; first NewFrame after the first full pair.
- **Transmit:**
  - Stimulus: LeftTxData = 24'h123456, RightTxData = 24'hABCDEF.
  - Required: the bench deserializer recovers both values; slot bits 24–31 are 0.
  - Also loop back `de_coder_port` (its DAC_SDATA → this block, this block's ADC_SDATA → its ADC_SDATA) → the words match end to end.
- **Mid-frame TX change:** change LeftTxData from 123456 to 0FFFFF mid-right-slot → the current frame is unchanged and the next left slot carries 0FFFFF.
- **Reset mid-operation:** assert reset during the 10th bit of a right word → all outputs are 0 on the next cycle, and the next NewFrame comes only after a new lock and a full left+right pair.
- **Frame check:**
  - With `I2S_SLAVE_FRAME_CHECK_EN` defined, a master sending one 31-BCLK half-frame → exactly one FrameErr pulse, and data stays correct on subsequent frames.
  - Without the macro, FrameErr stays 0.
